// File: rtl/ones_counter_stream_if.sv
// Stream bundle for ones_counter_stream: word input channel plus frame-result output channel.
interface ones_counter_stream_if #(
  parameter int W     = 127,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_count;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_sat
  );
endinterface

// File: rtl/ones_counter_stream.sv
// Counts the ones in every word of a frame and presents a saturating per-frame total.
// Define ONES_CNT_PIPE_EN to register the popcount tree output ahead of the accumulator.
module ones_counter_stream #(
  parameter int W     = 127,
  parameter int ACC_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  ones_counter_stream_if.slave bus
);
  localparam int CW     = $clog2(W + 1);
  localparam int LEAVES = 1 << $clog2(W);
  localparam int SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_load_out;
  logic             w_clear;
  logic             w_accept;
  logic [CW-1:0]    w_pc;
  logic [CW-1:0]    w_add_pc;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0] w_next_acc;
  logic             w_next_sat;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [ACC_W-1:0] r_out_count;
  logic             r_out_sat;

  // Pairwise reduction, level by level; every node is CW bits since no partial sum exceeds W.
  function automatic logic [CW-1:0] f_popcount(input logic [W-1:0] d);
    logic [LEAVES-1:0] pad;
    logic [CW-1:0]     node [LEAVES];
    pad = LEAVES'(d);
    for (int i = 0; i < LEAVES; i++) begin
      node[i]    = '0;
      node[i][0] = pad[i];
    end
    for (int n = LEAVES; n > 1; n = n / 2) begin
      for (int i = 0; i < n / 2; i++) node[i] = node[2*i] + node[2*i+1];
    end
    return node[0];
  endfunction

  assign w_pc     = f_popcount(bus.in_data);
  assign w_accept = bus.in_valid && w_in_ready;

`ifdef ONES_CNT_PIPE_EN
  logic [CW-1:0] r_pipe_pc;
  logic          r_pipe_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe_pc  <= '0;
      r_pipe_vld <= 1'b0;
    end else begin
      r_pipe_vld <= w_accept;
      if (w_accept) r_pipe_pc <= w_pc;
    end
  end

  assign w_add_pc = r_pipe_vld ? r_pipe_pc : '0;
`else
  assign w_add_pc = w_accept ? w_pc : '0;
`endif

  assign w_sum      = {1'b0, r_acc} + SUM_W'(w_add_pc);
  assign w_next_acc = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_next_sat = r_sat | w_sum[ACC_W];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ACCUM;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_load_out   = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) begin
`ifdef ONES_CNT_PIPE_EN
          w_next_state = S_DRAIN;
`else
          w_next_state = S_HOLD;
          w_load_out   = 1'b1;
`endif
        end
      end
      S_DRAIN: begin
        w_next_state = S_HOLD;
        w_load_out   = 1'b1;
      end
      S_HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = S_ACCUM;
          w_clear      = 1'b1;
        end
      end
      default: w_next_state = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_clear) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else begin
        r_acc <= w_next_acc;
        r_sat <= w_next_sat;
      end
      if (w_load_out) begin
        r_out_count <= w_next_acc;
        r_out_sat   <= w_next_sat;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_ones_counter_stream.sv
// Self-checking bench: a 16-bit and an 8-bit accumulator instance share one stimulus stream.
module tb_ones_counter_stream;
  localparam int W      = 127;
  localparam int ACC_W  = 16;
  localparam int ACC_W8 = 8;
`ifdef ONES_CNT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [W-1:0] ONES = '1;

  typedef struct packed {
    int                nwords;
    logic [2:0][W-1:0] words;
    int                cnt16;
    int                cnt8;
    bit                sat8;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ones_counter_stream_if #(.W(W), .ACC_W(ACC_W))  bus16 ();
  ones_counter_stream_if #(.W(W), .ACC_W(ACC_W8)) bus8 ();

  assign bus8.in_valid  = bus16.in_valid;
  assign bus8.in_data   = bus16.in_data;
  assign bus8.in_last   = bus16.in_last;
  assign bus8.out_ready = bus16.out_ready;

  ones_counter_stream #(.W(W), .ACC_W(ACC_W))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus16));
  ones_counter_stream #(.W(W), .ACC_W(ACC_W8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] q_words[$];
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic vec_t mkv(input int n, input logic [W-1:0] w0, input logic [W-1:0] w1,
                               input logic [W-1:0] w2, input int c16, input int c8, input bit s8);
    vec_t v;
    v.nwords   = n;
    v.words    = '0;
    v.words[0] = w0;
    v.words[1] = w1;
    v.words[2] = w2;
    v.cnt16    = c16;
    v.cnt8     = c8;
    v.sat8     = s8;
    return v;
  endfunction

  // Reference: frame total is the plain sum of per-word ones, clamped to the result width.
  function automatic int model_total();
    int t = 0;
    foreach (q_words[i]) t += $countones(q_words[i]);
    return t;
  endfunction

  function automatic int clamp(input int t, input int accw);
    int mx = (1 << accw) - 1;
    return (t > mx) ? mx : t;
  endfunction

  task automatic drive_idle();
    bus16.in_valid = 1'b0;
    bus16.in_last  = 1'b0;
    bus16.in_data  = '0;
  endtask

  task automatic do_reset(input int cycles);
    drive_idle();
    bus16.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    check("rst/out_valid", 32'(bus16.out_valid), 0);
    check("rst/out_count", 32'(bus16.out_count), 0);
    check("rst/out_sat", 32'(bus16.out_sat), 0);
    check("rst/in_ready", 32'(bus16.in_ready), 1);
    check("rst/out_count8", 32'(bus8.out_count), 0);
  endtask

  // Presents q_words one per cycle (optionally with idle gaps carrying junk); returns at the
  // negedge following the edge that accepted the final word.
  task automatic send_words(input bit with_last, input bit gaps);
    for (int i = 0; i < q_words.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus16.in_valid = 1'b0;
        bus16.in_data  = rand_word();
        bus16.in_last  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      check("accum/in_ready", 32'(bus16.in_ready), 1);
      bus16.in_valid = 1'b1;
      bus16.in_data  = q_words[i];
      bus16.in_last  = with_last && (i == q_words.size() - 1);
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic await_result(input string tag, output bit ok);
    int budget;
    budget = 0;
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) @(negedge clk);
      check({tag, "/in_ready_busy"}, 32'(bus16.in_ready), 0);
      check({tag, "/out_valid_latency"}, 32'(bus16.out_valid), (k == LAT) ? 1 : 0);
    end
    ok = 1'b1;
    while (!bus16.out_valid && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (!bus16.out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s/out_valid_timeout: got 0, expected 1 within %0d cycles", tag, budget);
      ok = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int c16, input bit s16, input int c8,
                             input bit s8, input int hold);
    bit ok;
    await_result(tag, ok);
    if (ok) begin
      check({tag, "/count16"}, 32'(bus16.out_count), c16);
      check({tag, "/sat16"}, 32'(bus16.out_sat), 32'(s16));
      check({tag, "/out_valid8"}, 32'(bus8.out_valid), 1);
      check({tag, "/count8"}, 32'(bus8.out_count), c8);
      check({tag, "/sat8"}, 32'(bus8.out_sat), 32'(s8));
      for (int h = 0; h < hold; h++) begin
        bus16.in_valid = 1'b1;
        bus16.in_data  = ONES;
        bus16.in_last  = 1'b1;
        @(negedge clk);
        check({tag, "/hold_valid"}, 32'(bus16.out_valid), 1);
        check({tag, "/hold_count"}, 32'(bus16.out_count), c16);
        check({tag, "/hold_in_ready"}, 32'(bus16.in_ready), 0);
      end
      drive_idle();
      bus16.out_ready = 1'b1;
      @(negedge clk);
      bus16.out_ready = 1'b0;
      check({tag, "/post_hs_valid"}, 32'(bus16.out_valid), 0);
      check({tag, "/post_hs_in_ready"}, 32'(bus16.in_ready), 1);
      check({tag, "/post_hs_count"}, 32'(bus16.out_count), c16);
      check({tag, "/post_hs_count8"}, 32'(bus8.out_count), c8);
    end
  endtask

  task automatic run_model_frame(input string tag, input bit gaps, input int hold);
    int t;
    t = model_total();
    send_words(1'b1, gaps);
    check_frame(tag, clamp(t, ACC_W), t > clamp(t, ACC_W), clamp(t, ACC_W8),
                t > clamp(t, ACC_W8), hold);
  endtask

  initial begin
    bit ok;
    int nw;
    int mode;
    logic [W-1:0] w;

    tbl[0] = mkv(1, ONES, '0, '0, 127, 127, 1'b0);
    tbl[1] = mkv(3, W'(1), ONES, '0, 128, 128, 1'b0);
    tbl[2] = mkv(1, W'(7), '0, '0, 3, 3, 1'b0);
    tbl[3] = mkv(3, ONES, ONES, ONES, 381, 255, 1'b1);
    tbl[4] = mkv(1, W'(5'h1F), '0, '0, 5, 5, 1'b0);
    tbl[5] = mkv(2, '0, '0, '0, 0, 0, 1'b0);
    tbl[6] = mkv(3, ONES, ONES, W'(1), 255, 255, 1'b0);
    tbl[7] = mkv(3, ONES, ONES, W'(3), 256, 255, 1'b1);

    drive_idle();
    bus16.out_ready = 1'b0;
    do_reset(2);

    foreach (tbl[i]) begin
      q_words.delete();
      for (int j = 0; j < tbl[i].nwords; j++) q_words.push_back(tbl[i].words[j]);
      send_words(1'b1, 1'b0);
      check_frame($sformatf("vec%0d", i), tbl[i].cnt16, 1'b0, tbl[i].cnt8, tbl[i].sat8, 0);
    end

    // Back-to-back 1/127/0 frame, result held off for five cycles with junk offered, then pop 3.
    q_words = '{W'(1), ONES, '0};
    send_words(1'b1, 1'b0);
    check_frame("hold5", 128, 1'b0, 128, 1'b0, 5);
    q_words = '{W'(7)};
    send_words(1'b1, 1'b0);
    check_frame("after_hold", 3, 1'b0, 3, 1'b0, 0);

    // Reset in the middle of a frame discards the partial total.
    q_words = '{W'(64'hFFFF_FFFF_FFFF_FFFF), W'(64'hFFFF_FFFF_FFFF_FFFF)};
    send_words(1'b0, 1'b0);
    do_reset(1);
    q_words = '{W'(10'h3FF)};
    send_words(1'b1, 1'b0);
    check_frame("after_midrst", 10, 1'b0, 10, 1'b0, 0);

    // Reset while a result is pending in HOLD.
    q_words = '{ONES};
    send_words(1'b1, 1'b0);
    await_result("pre_holdrst", ok);
    do_reset(1);
    q_words = '{W'(5'h1F)};
    send_words(1'b1, 1'b0);
    check_frame("after_holdrst", 5, 1'b0, 5, 1'b0, 0);

    for (int f = 0; f < 40; f++) begin
      q_words.delete();
      nw = $urandom_range(1, 6);
      for (int j = 0; j < nw; j++) begin
        mode = $urandom_range(0, 3);
        case (mode)
          0:       w = '0;
          1:       w = ONES;
          2:       w = rand_word();
          default: w = rand_word() & rand_word() & rand_word();
        endcase
        q_words.push_back(w);
      end
      run_model_frame($sformatf("rnd%0d", f), 1'b1, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
